// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters through a round-robin arbiter.
// One transfer in flight; SETUP/ACCESS sequencing with an ACCESS wait-state timeout.
module apb_master_arbiter #(
    parameter int APB_ADDR_WIDTH    = 32,
    parameter int APB_DATA_WIDTH    = 32,
    parameter int APB_SLAVE_DEVICES = 4,
    parameter int NUM_REQ           = 2,
    parameter int SEL_LSB           = 12,
    parameter int TIMEOUT           = 16
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*APB_DATA_WIDTH/8-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]                req_prot,
    output logic [NUM_REQ-1:0]                  done,
    output logic [APB_DATA_WIDTH-1:0]           rsp_rdata,
    output logic                                rsp_err,
    output logic [APB_ADDR_WIDTH-1:0]           addr,
    output logic [APB_SLAVE_DEVICES-1:0]        sels,
    output logic                                penable,
    output logic                                write,
    output logic [APB_DATA_WIDTH-1:0]           wdata,
    output logic [APB_DATA_WIDTH/8-1:0]         strb,
    output logic [2:0]                          prot,
    input  logic                                master_ready,
    input  logic [APB_DATA_WIDTH-1:0]           rdata,
    input  logic                                master_error_in
);
    // state  | meaning
    // IDLE   | no transfer in flight; arbitrate among pending requests
    // SETUP  | APB setup phase: select asserted, penable low, one cycle
    // ACCESS | APB access phase: wait for ready or wait-state timeout

    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int SB = APB_DATA_WIDTH / 8;
    localparam int SW = $clog2(APB_SLAVE_DEVICES);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;
    logic          gnt_vld;
    logic          fin_ok;
    logic          fin_to;
    logic [CW-1:0] wait_cnt;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i >= NUM_REQ) ? IW'(int'(rr_ptr) + i - NUM_REQ)
                                                 : IW'(int'(rr_ptr) + i);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fin_ok    = 1'b0;
        fin_to    = 1'b0;
        unique case (state)
            IDLE:   if (gnt_vld) state_nxt = SETUP;
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                if (master_ready) begin
                    fin_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    fin_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            owner     <= '0;
            wait_cnt  <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            addr      <= '0;
            write     <= 1'b0;
            wdata     <= '0;
            strb      <= '0;
            prot      <= '0;
        end else begin
            done <= '0;
            if (state == IDLE && gnt_vld) begin
                owner    <= gnt_idx;
                rr_ptr   <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
                addr     <= req_addr[int'(gnt_idx)*AW +: AW];
                write    <= req_write[gnt_idx];
                wdata    <= req_wdata[int'(gnt_idx)*DW +: DW];
                strb     <= req_write[gnt_idx] ? req_strb[int'(gnt_idx)*SB +: SB] : '0;
                prot     <= req_prot[int'(gnt_idx)*3 +: 3];
                wait_cnt <= '0;
            end
            if (state == ACCESS && !master_ready)
                wait_cnt <= wait_cnt + CW'(1);
            // A timed-out access reports an error with zeroed read data.
            if (fin_ok || fin_to) begin
                done[owner] <= 1'b1;
                rsp_rdata   <= (fin_ok && !write) ? rdata : '0;
                rsp_err     <= fin_to | master_error_in;
            end
        end
    end

    assign penable = (state == ACCESS);
    assign sels    = (state == SETUP || state == ACCESS)
                     ? (APB_SLAVE_DEVICES'(1) << addr[SEL_LSB +: SW]) : '0;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus randomized
// multi-requester traffic checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_apb_master_arbiter;
    localparam int AW = 32, DW = 32, NS = 4, NR = 2, SL = 12, TO = 16, SB = DW / 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_write;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SB-1:0]  req_strb;
    logic [NR*3-1:0]   req_prot;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     addr;
    logic [NS-1:0]     sels;
    logic              penable;
    logic              write;
    logic [DW-1:0]     wdata;
    logic [SB-1:0]     strb;
    logic [2:0]        prot;
    logic              master_ready;
    logic [DW-1:0]     rdata;
    logic              master_error_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int slv_wait = 0;
    int acc_cnt = 0;

    apb_master_arbiter #(
        .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .APB_SLAVE_DEVICES(NS),
        .NUM_REQ(NR), .SEL_LSB(SL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .addr(addr), .sels(sels),
        .penable(penable), .write(write), .wdata(wdata), .strb(strb), .prot(prot),
        .master_ready(master_ready), .rdata(rdata), .master_error_in(master_error_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: hold ready low for slv_wait ACCESS cycles, then raise it.
    initial begin
        master_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (penable === 1'b1) begin
                acc_cnt++;
                master_ready = (acc_cnt > slv_wait);
            end else begin
                acc_cnt = 0;
                master_ready = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observations of one transfer (collected here, compared by each test).
    logic [AW-1:0] o_addr;
    logic [NS-1:0] o_sels;
    logic          o_pen, o_write, o_err, o_stable, o_early, o_to;
    logic [DW-1:0] o_wdata, o_rdata;
    logic [SB-1:0] o_strb;
    logic [2:0]    o_prot;
    logic [NR-1:0] o_done;
    int            o_acc, o_setup_cyc, o_done_cyc;

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [SB-1:0] s, input logic [2:0] p);
        req_addr[i*AW +: AW] = a;
        req_write[i]         = w;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SB +: SB] = s;
        req_prot[i*3 +: 3]   = p;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge before SETUP; returns at the negedge of the done cycle.
    task automatic observe();
        int n;
        o_to = 1'b0; o_stable = 1'b1; o_early = 1'b0; o_acc = 0;
        o_done = '0; o_rdata = '0; o_err = 1'b0; o_done_cyc = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (done !== '0) o_early = 1'b1;
        end while (sels === '0 && n < 60);
        if (sels === '0) begin o_to = 1'b1; return; end
        o_addr = addr; o_sels = sels; o_pen = penable; o_write = write;
        o_wdata = wdata; o_strb = strb; o_prot = prot; o_setup_cyc = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (penable === 1'b1) begin
                o_acc++;
                if (sels !== o_sels || addr !== o_addr || write !== o_write ||
                    wdata !== o_wdata || strb !== o_strb || prot !== o_prot) o_stable = 1'b0;
                if (done !== '0) o_early = 1'b1;
            end
        end while (penable === 1'b1 && n < 100);
        if (penable === 1'b1) begin o_to = 1'b1; return; end
        o_done = done; o_rdata = rsp_rdata; o_err = rsp_err; o_done_cyc = cyc;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++; if (sels !== '0) begin errors++; $display("FAIL reset_sels: got %h want 0", sels); end
        checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b want 0", penable); end
        checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({addr, write, wdata, strb, prot} !== '0) begin errors++;
            $display("FAIL reset_bus: addr %h write %b wdata %h strb %h prot %h want all 0", addr, write, wdata, strb, prot); end
        checks++; if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin errors++;
            $display("FAIL reset_rsp: rdata %h err %b want 0/0", rsp_rdata, rsp_err); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int c0;
        do_reset();
        slv_wait = 0; master_error_in = 1'b0; rdata = 32'h5555_AAAA;
        set_req(0, 32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
        c0 = cyc;
        req[0] = 1'b1;
        observe();
        req[0] = 1'b0;
        checks++; if (o_to) begin errors++; $display("FAIL sw_timeout: transfer not observed"); end
        checks++; if (o_setup_cyc !== c0 + 1) begin errors++; $display("FAIL sw_setup_cycle: got %0d want %0d", o_setup_cyc - c0, 1); end
        checks++; if (o_sels !== 4'b0100 || o_pen !== 1'b0) begin errors++; $display("FAIL sw_setup: sels %b pen %b want 0100/0", o_sels, o_pen); end
        checks++; if (o_addr !== 32'h2004 || o_wdata !== 32'hDEAD_BEEF || o_write !== 1'b1 || o_strb !== 4'hF || o_prot !== 3'b010) begin
            errors++; $display("FAIL sw_bus: addr %h wdata %h write %b strb %h prot %b", o_addr, o_wdata, o_write, o_strb, o_prot); end
        checks++; if (o_acc !== 1 || !o_stable) begin errors++; $display("FAIL sw_access: got %0d cycles stable %b want 1/1", o_acc, o_stable); end
        checks++; if (o_done_cyc !== c0 + 3 || o_done !== 2'b01) begin errors++;
            $display("FAIL sw_done: cycle %0d done %b want 3/01", o_done_cyc - c0, o_done); end
        checks++; if (o_err !== 1'b0 || o_rdata !== '0) begin errors++; $display("FAIL sw_rsp: err %b rdata %h want 0/0", o_err, o_rdata); end
        @(negedge clk);
        checks++; if (done !== '0 || sels !== '0 || penable !== 1'b0) begin errors++;
            $display("FAIL sw_after: done %b sels %b pen %b want 0", done, sels, penable); end
        checks++; if (addr !== 32'h2004) begin errors++; $display("FAIL sw_hold_addr: got %h want 00002004", addr); end
    endtask

    task automatic test_wait_read();
        do_reset();
        slv_wait = 3; master_error_in = 1'b0; rdata = 32'h1234_5678;
        set_req(1, 32'h0000_3000, 1'b0, 32'hAAAA_5555, 4'hF, 3'b001);
        req[1] = 1'b1;
        observe();
        req[1] = 1'b0;
        checks++; if (o_to) begin errors++; $display("FAIL rd_timeout: transfer not observed"); end
        checks++; if (o_sels !== 4'b1000 || o_strb !== 4'h0) begin errors++; $display("FAIL rd_setup: sels %b strb %h want 1000/0", o_sels, o_strb); end
        checks++; if (o_acc !== 4) begin errors++; $display("FAIL rd_access: got %0d cycles want 4", o_acc); end
        checks++; if (o_done !== 2'b10 || o_rdata !== 32'h1234_5678 || o_err !== 1'b0) begin errors++;
            $display("FAIL rd_rsp: done %b rdata %h err %b want 10/12345678/0", o_done, o_rdata, o_err); end
        rdata = 32'hCAFE_0000;
        repeat (3) @(negedge clk);
        checks++; if (rsp_rdata !== 32'h1234_5678 || done !== '0) begin errors++;
            $display("FAIL rd_hold: rdata %h done %b want 12345678/0", rsp_rdata, done); end
    endtask

    task automatic test_round_robin();
        int ptr;
        logic [NR-1:0] e_done;
        do_reset();
        slv_wait = 0; master_error_in = 1'b0;
        set_req(0, 32'h0000_1010, 1'b1, 32'h1111_1111, 4'h3, 3'b000);
        set_req(1, 32'h0000_2020, 1'b1, 32'h2222_2222, 4'hC, 3'b111);
        ptr = 0;
        req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            observe();
            if (k == 5) req = '0;
            e_done = '0; e_done[ptr] = 1'b1;
            checks++; if (o_to || o_done !== e_done || o_early) begin errors++;
                $display("FAIL rr_grant%0d: done %b early %b want %b", k, o_done, o_early, e_done); end
            checks++; if (o_addr !== req_addr[ptr*AW +: AW]) begin errors++;
                $display("FAIL rr_addr%0d: got %h want %h", k, o_addr, req_addr[ptr*AW +: AW]); end
            ptr = (ptr + 1) % NR;
        end
        @(negedge clk);
        checks++; if (done !== '0 || sels !== '0) begin errors++; $display("FAIL rr_drain: done %b sels %b want 0", done, sels); end
    endtask

    task automatic test_timeout();
        do_reset();
        slv_wait = 1000; master_error_in = 1'b0; rdata = 32'hFFFF_FFFF;
        set_req(0, 32'h0000_1008, 1'b0, 32'h0, 4'h0, 3'b000);
        req[0] = 1'b1;
        observe();
        req[0] = 1'b0;
        checks++; if (o_acc !== TO || o_to) begin errors++; $display("FAIL to_access: got %0d cycles want %0d", o_acc, TO); end
        checks++; if (o_done !== 2'b01 || o_err !== 1'b1 || o_rdata !== '0) begin errors++;
            $display("FAIL to_rsp: done %b err %b rdata %h want 01/1/0", o_done, o_err, o_rdata); end
        @(negedge clk);
        checks++; if (sels !== '0 || penable !== 1'b0) begin errors++; $display("FAIL to_idle: sels %b pen %b want 0", sels, penable); end
    endtask

    task automatic test_error_strb();
        do_reset();
        slv_wait = 1; master_error_in = 1'b1; rdata = 32'h0BAD_0BAD;
        set_req(0, 32'h0000_0040, 1'b1, 32'h0102_0304, 4'h5, 3'b100);
        req[0] = 1'b1;
        observe();
        req[0] = 1'b0;
        checks++; if (o_done !== 2'b01 || o_err !== 1'b1 || o_acc !== 2) begin errors++;
            $display("FAIL err_write: done %b err %b acc %0d want 01/1/2", o_done, o_err, o_acc); end
        master_error_in = 1'b0;
        set_req(1, 32'h0000_1044, 1'b0, 32'h0, 4'hF, 3'b000);
        req[1] = 1'b1;
        observe();
        req[1] = 1'b0;
        checks++; if (o_strb !== 4'h0 || o_write !== 1'b0) begin errors++; $display("FAIL rd_strb: strb %h write %b want 0/0", o_strb, o_write); end
        checks++; if (o_done !== 2'b10 || o_err !== 1'b0 || o_rdata !== 32'h0BAD_0BAD) begin errors++;
            $display("FAIL rd_after_err: done %b err %b rdata %h want 10/0/0bad0bad", o_done, o_err, o_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int n;
        do_reset();
        slv_wait = 1000; master_error_in = 1'b0;
        set_req(0, 32'h0000_2000, 1'b1, 32'h7777_7777, 4'hF, 3'b000);
        set_req(1, 32'h0000_1000, 1'b1, 32'h8888_8888, 4'hF, 3'b000);
        req[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (penable !== 1'b1 && n < 20);
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL mid_reach_access: penable %b want 1", penable); end
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (sels !== '0 || penable !== 1'b0 || done !== '0) begin errors++;
            $display("FAIL mid_reset: sels %b pen %b done %b want 0", sels, penable, done); end
        req = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (sels !== '0 || done !== '0) begin errors++; $display("FAIL mid_release: sels %b done %b want 0", sels, done); end
        slv_wait = 0;
        req = 2'b11;
        observe();
        req = '0;
        checks++; if (o_to || o_early || o_done !== 2'b01 || o_addr !== 32'h2000) begin errors++;
            $display("FAIL mid_first_grant: done %b addr %h early %b want 01/00002000/0", o_done, o_addr, o_early); end
    endtask

    task automatic test_random();
        logic [AW-1:0] ra[NR];
        logic          rw[NR];
        logic [DW-1:0] rd[NR];
        logic [SB-1:0] rs[NR];
        logic [2:0]    rp[NR];
        logic [NR-1:0] pending, e_done;
        logic [NS-1:0] e_sels;
        logic [DW-1:0] e_rdata;
        logic [SB-1:0] e_strb;
        logic [1:0]    e_slv;
        int ptr, owner, e_acc, r;
        logic e_err, e_to;
        do_reset();
        ptr = 0;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NR; i++) begin
                ra[i] = $urandom; ra[i][7:0] = 8'(i);
                rw[i] = 1'($urandom_range(0, 1));
                rd[i] = $urandom; rs[i] = 4'($urandom); rp[i] = 3'($urandom);
                set_req(i, ra[i], rw[i], rd[i], rs[i], rp[i]);
            end
            pending = 2'($urandom_range(1, 3));
            req = pending;
            while (pending != '0) begin
                r = $urandom_range(0, 9);
                slv_wait = (r == 9) ? 20 : r % 4;
                master_error_in = ($urandom_range(0, 3) == 0);
                rdata = $urandom;
                owner = -1;
                for (int j = 0; j < NR; j++)
                    if (owner < 0 && pending[(ptr + j) % NR]) owner = (ptr + j) % NR;
                observe();
                req[owner] = 1'b0;
                pending[owner] = 1'b0;
                ptr = (owner + 1) % NR;
                e_to    = (slv_wait >= TO);
                e_acc   = e_to ? TO : slv_wait + 1;
                e_err   = e_to | master_error_in;
                e_rdata = (e_to || rw[owner]) ? '0 : rdata;
                e_strb  = rw[owner] ? rs[owner] : '0;
                e_slv   = ra[owner][SL +: 2];
                e_sels  = '0; e_sels[e_slv] = 1'b1;
                e_done  = '0; e_done[owner] = 1'b1;
                checks++; if (o_to) begin errors++; $display("FAIL rnd_hang it%0d: transfer not completed", it); end
                checks++; if (o_addr !== ra[owner] || o_sels !== e_sels || o_pen !== 1'b0) begin errors++;
                    $display("FAIL rnd_setup it%0d: addr %h sels %b pen %b want %h/%b/0", it, o_addr, o_sels, o_pen, ra[owner], e_sels); end
                checks++; if (o_write !== rw[owner] || o_wdata !== rd[owner] || o_strb !== e_strb || o_prot !== rp[owner]) begin errors++;
                    $display("FAIL rnd_bus it%0d: w %b d %h s %h p %b want %b/%h/%h/%b", it, o_write, o_wdata, o_strb, o_prot, rw[owner], rd[owner], e_strb, rp[owner]); end
                checks++; if (o_acc !== e_acc || !o_stable || o_early) begin errors++;
                    $display("FAIL rnd_access it%0d: acc %0d stable %b early %b want %0d/1/0", it, o_acc, o_stable, o_early, e_acc); end
                checks++; if (o_done !== e_done || o_rdata !== e_rdata || o_err !== e_err) begin errors++;
                    $display("FAIL rnd_rsp it%0d: done %b rdata %h err %b want %b/%h/%b", it, o_done, o_rdata, o_err, e_done, e_rdata, e_err); end
            end
        end
        @(negedge clk);
        checks++; if (sels !== '0 || done !== '0) begin errors++; $display("FAIL rnd_drain: sels %b done %b want 0", sels, done); end
    endtask

    initial begin
        req = '0; req_addr = '0; req_write = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        rdata = '0; master_error_in = 1'b0;
        test_reset();
        test_single_write();
        test_wait_read();
        test_round_robin();
        test_timeout();
        test_error_strb();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
